// File: rtl/inst_mem_pkg.sv
// Shared types for the instruction-memory arbiter: FSM state, transaction owner
// and default word/address widths.
package inst_mem_pkg;

    localparam int DEF_INST_WIDTH      = 32;
    localparam int DEF_INST_ADDR_WIDTH = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    typedef enum logic {
        OWN_LD   = 1'b0,
        OWN_CORE = 1'b1
    } owner_t;

endpackage

// File: rtl/inst_mem_arbiter_rr_arb2.sv
// Two-way round-robin picker; on a tie the requester that did not win last time
// is chosen. last_q only moves when the caller commits the grant.
module rr_arb2
    import inst_mem_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   req_ld_i,
    input  logic   req_core_i,
    input  logic   update_i,
    output logic   grant_valid_o,
    output owner_t grant_owner_o
);

    owner_t last_q;

    always_comb begin
        grant_valid_o = req_ld_i | req_core_i;
        if (req_ld_i && req_core_i) begin
            grant_owner_o = (last_q == OWN_LD) ? OWN_CORE : OWN_LD;
        end else if (req_core_i) begin
            grant_owner_o = OWN_CORE;
        end else begin
            grant_owner_o = OWN_LD;
        end
    end

    // Resetting to OWN_LD makes the core win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OWN_LD;
        end else if (update_i && grant_valid_o) begin
            last_q <= grant_owner_o;
        end
    end

endmodule

// File: rtl/inst_mem_arbiter.sv
// Shares one instruction-memory port between the boot loader and the core fetch
// path, one transaction at a time, with a valid-or-timeout completion.
module inst_mem_arbiter
    import inst_mem_pkg::*;
#(
    parameter int INST_WIDTH      = DEF_INST_WIDTH,
    parameter int INST_ADDR_WIDTH = DEF_INST_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES  = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_req,
    input  logic                       ld_we,
    input  logic [INST_ADDR_WIDTH-1:0] ld_addr,
    input  logic [INST_WIDTH-1:0]      ld_wdata,
    output logic                       ld_ack,
    input  logic                       core_req,
    input  logic [INST_ADDR_WIDTH-1:0] core_addr,
    output logic                       core_ack,
    output logic [INST_WIDTH-1:0]      rsp_rdata,
    output logic                       rsp_err,
    output logic                       busy,
    output logic                       mem_we,
    output logic                       mem_request,
    output logic [INST_ADDR_WIDTH-1:0] mem_addr,
    output logic [INST_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_valid,
    input  logic [INST_WIDTH-1:0]      mem_rdata
);

    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] CNT_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t                      state_q, state_d;
    owner_t                      owner_q, owner_d;
    logic [TO_W-1:0]             cnt_q, cnt_d;
    logic                        ld_ack_q, ld_ack_d;
    logic                        core_ack_q, core_ack_d;
    logic [INST_WIDTH-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                        rsp_err_q, rsp_err_d;
    logic                        busy_q, busy_d;
    logic                        mem_we_q, mem_we_d;
    logic                        mem_request_q, mem_request_d;
    logic [INST_ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [INST_WIDTH-1:0]       mem_wdata_q, mem_wdata_d;

    logic   arb_update;
    logic   grant_valid;
    owner_t grant_owner;

    rr_arb2 u_rr_arb2 (
        .clk           (clk),
        .rst           (rst),
        .req_ld_i      (ld_req),
        .req_core_i    (core_req),
        .update_i      (arb_update),
        .grant_valid_o (grant_valid),
        .grant_owner_o (grant_owner)
    );

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        ld_ack_d      = 1'b0;
        core_ack_d    = 1'b0;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        mem_we_d      = mem_we_q;
        mem_request_d = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        arb_update    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_valid) begin
                    arb_update    = 1'b1;
                    owner_d       = grant_owner;
                    mem_request_d = 1'b1;
                    state_d       = ST_ISSUE;
                    if (grant_owner == OWN_CORE) begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = core_addr;
                        mem_wdata_d = '0;
                    end else begin
                        mem_we_d    = ld_we;
                        mem_addr_d  = ld_addr;
                        mem_wdata_d = ld_wdata;
                    end
                end
            end
            ST_ISSUE: begin
                if (mem_valid) begin
                    rsp_rdata_d = mem_rdata;
                    rsp_err_d   = 1'b0;
                    ld_ack_d    = (owner_q == OWN_LD);
                    core_ack_d  = (owner_q == OWN_CORE);
                    state_d     = ST_RESP;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mem_valid) begin
                    rsp_rdata_d = mem_rdata;
                    rsp_err_d   = 1'b0;
                    ld_ack_d    = (owner_q == OWN_LD);
                    core_ack_d  = (owner_q == OWN_CORE);
                    state_d     = ST_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    ld_ack_d    = (owner_q == OWN_LD);
                    core_ack_d  = (owner_q == OWN_CORE);
                    state_d     = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // RESP: response fields only mean something alongside an ack.
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b0;
                mem_we_d    = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_LD;
            cnt_q         <= '0;
            ld_ack_q      <= 1'b0;
            core_ack_q    <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            busy_q        <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_request_q <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            ld_ack_q      <= ld_ack_d;
            core_ack_q    <= core_ack_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            busy_q        <= busy_d;
            mem_we_q      <= mem_we_d;
            mem_request_q <= mem_request_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign ld_ack      = ld_ack_q;
    assign core_ack    = core_ack_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign busy        = busy_q;
    assign mem_we      = mem_we_q;
    assign mem_request = mem_request_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_inst_mem_arbiter.sv
// Self-checking bench for inst_mem_arbiter: directed scenarios plus a random
// mixed phase, checked against a transaction-level reference model.
module tb_inst_mem_arbiter;

    localparam int IW = 32;
    localparam int AW = 7;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req, ld_we, ld_ack;
    logic [AW-1:0] ld_addr;
    logic [IW-1:0] ld_wdata;
    logic          core_req, core_ack;
    logic [AW-1:0] core_addr;
    logic [IW-1:0] rsp_rdata;
    logic          rsp_err, busy, mem_we, mem_request;
    logic [AW-1:0] mem_addr;
    logic [IW-1:0] mem_wdata;
    logic          mem_valid;
    logic [IW-1:0] mem_rdata;

    always #5 clk = ~clk;

    inst_mem_arbiter #(
        .INST_WIDTH      (IW),
        .INST_ADDR_WIDTH (AW),
        .TIMEOUT_CYCLES  (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ld_req      (ld_req),
        .ld_we       (ld_we),
        .ld_addr     (ld_addr),
        .ld_wdata    (ld_wdata),
        .ld_ack      (ld_ack),
        .core_req    (core_req),
        .core_addr   (core_addr),
        .core_ack    (core_ack),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .mem_we      (mem_we),
        .mem_request (mem_request),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_valid   (mem_valid),
        .mem_rdata   (mem_rdata)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Memory contents as seen by the responder, and the model's expectation of them.
    logic [IW-1:0] mem_model [0:(1<<AW)-1];
    logic [IW-1:0] ref_mem   [0:(1<<AW)-1];
    int            mem_lat = 0;   // cycles from request to valid; -1 = never responds
    bit            stray   = 1'b0;
    bit            model_last_core = 1'b0;
    int            last_ack_cyc = 0;
    int            last_req_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic respond(input logic [AW-1:0] a, input logic w, input logic [IW-1:0] d);
        mem_valid = 1'b1;
        if (w) begin
            mem_model[a] = d;
            mem_rdata    = '0;
        end else begin
            mem_rdata = mem_model[a];
        end
    endtask

    // Memory responder: answers each request after mem_lat cycles.
    initial begin : responder
        bit            pend;
        int            cnt;
        logic [AW-1:0] a;
        logic          w;
        logic [IW-1:0] d;
        pend      = 1'b0;
        cnt       = 0;
        a         = '0;
        w         = 1'b0;
        d         = '0;
        mem_valid = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_valid = 1'b0;
            mem_rdata = '0;
            if (rst) begin
                pend = 1'b0;
            end else if (mem_request) begin
                a = mem_addr;
                w = mem_we;
                d = mem_wdata;
                if (mem_lat == 0) begin
                    respond(a, w, d);
                end else if (mem_lat > 0) begin
                    pend = 1'b1;
                    cnt  = mem_lat;
                end
            end else if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    pend = 1'b0;
                    respond(a, w, d);
                end
            end else if (stray) begin
                stray     = 1'b0;
                mem_valid = 1'b1;
                mem_rdata = $urandom;
            end
        end
    end

    // Called in an IDLE cycle with the request(s) already driven; follows one
    // transaction until its ack and checks it against the expected outcome.
    task automatic run_txn(input string tag, input bit exp_core, input logic [AW-1:0] exp_addr,
                           input bit exp_we, input logic [IW-1:0] exp_wdata, input int exp_lat,
                           input logic [IW-1:0] exp_rdata, input bit exp_err, input bit drop);
        int c;
        int pulses;
        bit done;
        bit unstable;
        c        = 0;
        pulses   = 0;
        done     = 1'b0;
        unstable = 1'b0;
        while (!done && c < 40) begin
            step();
            c++;
            if (mem_request) begin
                pulses++;
                last_req_cyc = cyc;
            end
            if (c == 1) begin
                check({tag, "/mem_request"}, 32'(mem_request), 32'd1);
                check({tag, "/mem_addr"}, 32'(mem_addr), 32'(exp_addr));
                check({tag, "/mem_we"}, 32'(mem_we), 32'(exp_we));
                if (!exp_core) check({tag, "/mem_wdata"}, mem_wdata, exp_wdata);
            end else if (mem_addr !== exp_addr || mem_we !== exp_we ||
                         (!exp_core && mem_wdata !== exp_wdata)) begin
                unstable = 1'b1;
            end
            if (ld_ack || core_ack) begin
                done = 1'b1;
                last_ack_cyc = cyc;
                check({tag, "/core_ack"}, 32'(core_ack), 32'(exp_core));
                check({tag, "/ld_ack"}, 32'(ld_ack), 32'(!exp_core));
                check({tag, "/latency"}, 32'(c), 32'(exp_lat));
                check({tag, "/rdata"}, rsp_rdata, exp_rdata);
                check({tag, "/err"}, 32'(rsp_err), 32'(exp_err));
                check({tag, "/busy"}, 32'(busy), 32'd1);
                if (drop) begin
                    if (exp_core) core_req = 1'b0;
                    else          ld_req   = 1'b0;
                end
            end
        end
        check({tag, "/ack_seen"}, 32'(done), 32'd1);
        check({tag, "/req_pulses"}, 32'(pulses), 32'd1);
        check({tag, "/stable"}, 32'(unstable), 32'd0);
    endtask

    function automatic int exp_latency(input int lat);
        return (lat < 0) ? 2 + TO : 2 + lat;
    endfunction

    initial begin
        bit            win_core;
        logic [AW-1:0] e_addr;
        bit            e_we;
        logic [IW-1:0] e_wdata, e_rdata;
        int            r, prev_ack;

        for (int i = 0; i < (1 << AW); i++) begin
            mem_model[i] = $urandom;
            ref_mem[i]   = mem_model[i];
        end
        rst = 1'b1; ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        core_req = 1'b0; core_addr = '0;
        repeat (3) step();

        check("rst/busy", 32'(busy), 32'd0);
        check("rst/mem_request", 32'(mem_request), 32'd0);
        check("rst/mem_we", 32'(mem_we), 32'd0);
        check("rst/acks", 32'({ld_ack, core_ack}), 32'd0);
        check("rst/mem_addr", 32'(mem_addr), 32'd0);
        check("rst/mem_wdata", mem_wdata, 32'd0);
        check("rst/rsp_rdata", rsp_rdata, 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        model_last_core = 1'b0;
        step();

        // Core read, zero-wait memory
        mem_model[5] = 32'hDEAD_BEEF;
        ref_mem[5]   = 32'hDEAD_BEEF;
        mem_lat = 0;
        core_addr = 7'h05; core_req = 1'b1;
        run_txn("core_zw", 1'b1, 7'h05, 1'b0, '0, 2, 32'hDEAD_BEEF, 1'b0, 1'b1);
        model_last_core = 1'b1;
        step();

        // Loader write, 3-cycle memory
        mem_lat = 3;
        ld_we = 1'b1; ld_addr = 7'h10; ld_wdata = 32'h0000_0013; ld_req = 1'b1;
        run_txn("ld_wr", 1'b0, 7'h10, 1'b1, 32'h13, 5, '0, 1'b0, 1'b1);
        ref_mem[7'h10] = 32'h13;
        model_last_core = 1'b0;
        ld_we = 1'b0;
        step();

        // Both requesters held continuously: alternation starting with the core
        ld_we = 1'($urandom); ld_addr = 7'($urandom); ld_wdata = $urandom; ld_req = 1'b1;
        core_addr = 7'($urandom); core_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            win_core = model_last_core ? 1'b0 : 1'b1;
            check("tie/order", 32'(win_core), 32'((i % 2) == 0));
            mem_lat = $urandom_range(3, 0);
            e_addr  = win_core ? core_addr : ld_addr;
            e_we    = win_core ? 1'b0 : ld_we;
            e_wdata = ld_wdata;
            e_rdata = e_we ? '0 : ref_mem[e_addr];
            run_txn("tie", win_core, e_addr, e_we, e_wdata, exp_latency(mem_lat), e_rdata, 1'b0, 1'b0);
            if (e_we) ref_mem[e_addr] = e_wdata;
            model_last_core = win_core;
            if (win_core) begin
                core_addr = 7'($urandom);
            end else begin
                ld_we = 1'($urandom); ld_addr = 7'($urandom); ld_wdata = $urandom;
            end
            step();
        end
        ld_req = 1'b0; core_req = 1'b0;
        step();

        // Memory never answers: timeout error, then a stray valid in IDLE
        mem_lat = -1;
        core_addr = 7'($urandom); core_req = 1'b1;
        run_txn("timeout", 1'b1, core_addr, 1'b0, '0, 2 + TO, '0, 1'b1, 1'b1);
        model_last_core = 1'b1;
        step();
        stray = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("stray/acks_busy", 32'({ld_ack, core_ack, busy}), 32'd0);
        end

        // Reset during WAIT of a loader write abandons it without an ack
        ld_we = 1'b1; ld_addr = 7'($urandom); ld_wdata = $urandom; ld_req = 1'b1;
        repeat (4) step();
        check("rstwait/busy_before", 32'(busy), 32'd1);
        rst = 1'b1; ld_req = 1'b0;
        step();
        check("rstwait/busy", 32'(busy), 32'd0);
        check("rstwait/mem_request", 32'(mem_request), 32'd0);
        check("rstwait/mem_we", 32'(mem_we), 32'd0);
        check("rstwait/acks", 32'({ld_ack, core_ack}), 32'd0);
        rst = 1'b0; ld_we = 1'b0;
        model_last_core = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rstwait/no_ack", 32'({ld_ack, core_ack}), 32'd0);
        end
        mem_lat = 2;
        core_addr = 7'($urandom); core_req = 1'b1;
        run_txn("post_rst", 1'b1, core_addr, 1'b0, '0, 4, ref_mem[core_addr], 1'b0, 1'b1);
        model_last_core = 1'b1;
        step();

        // Back-to-back core fetches over addresses 0..31
        core_addr = '0; core_req = 1'b1;
        prev_ack = 0;
        for (int i = 0; i < 32; i++) begin
            mem_lat = $urandom_range(3, 0);
            run_txn("b2b", 1'b1, 7'(i), 1'b0, '0, exp_latency(mem_lat), ref_mem[i], 1'b0, 1'b0);
            if (i > 0) check("b2b/req_gap", 32'(last_req_cyc - prev_ack), 32'd2);
            prev_ack = last_ack_cyc;
            if (i < 31) core_addr = 7'(i + 1);
            else        core_req  = 1'b0;
            step();
        end
        model_last_core = 1'b1;

        // Random mixed traffic; a losing requester keeps its request up
        for (int i = 0; i < 20; i++) begin
            if (!ld_req && $urandom_range(1, 0) == 1) begin
                ld_we = 1'($urandom); ld_addr = 7'($urandom); ld_wdata = $urandom; ld_req = 1'b1;
            end
            if (!core_req && ($urandom_range(1, 0) == 1 || !ld_req)) begin
                core_addr = 7'($urandom); core_req = 1'b1;
            end
            r = $urandom_range(7, 0);
            mem_lat = (r == 7) ? -1 : r % 4;
            win_core = (ld_req && core_req) ? !model_last_core : core_req;
            e_addr  = win_core ? core_addr : ld_addr;
            e_we    = win_core ? 1'b0 : ld_we;
            e_wdata = ld_wdata;
            e_rdata = (e_we || mem_lat < 0) ? '0 : ref_mem[e_addr];
            run_txn("rand", win_core, e_addr, e_we, e_wdata, exp_latency(mem_lat), e_rdata,
                    (mem_lat < 0), 1'b1);
            if (e_we && mem_lat >= 0) ref_mem[e_addr] = e_wdata;
            model_last_core = win_core;
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/inst_mem_arbiter.md
Name: inst_mem_arbiter

Overview:
- Shares the single instruction-memory port between two requesters: the boot loader (writes or reads program words) and the core fetch path (read-only).
- Sits between both requesters and the instruction memory.
- Round-robin arbitration with one outstanding transaction.
- Each transaction completes on the memory valid strobe, or with an error when a timeout expires.

Parameters:
- INST_WIDTH, 32, instruction/data word width.
- INST_ADDR_WIDTH, 7, word address width.
- TIMEOUT_CYCLES, 15, maximum WAIT cycles before an error completion (>=1).
- Local TO_W = $clog2(TIMEOUT_CYCLES+1).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- ld_req  in  1  loader request; held until ld_ack.
- ld_we  in  1  loader write (1) / read (0).
- ld_addr  in  INST_ADDR_WIDTH  loader address.
- ld_wdata  in  INST_WIDTH  loader write data.
- ld_ack  out  1  one-cycle completion pulse to loader.
- core_req  in  1  fetch request; held until core_ack.
- core_addr  in  INST_ADDR_WIDTH  fetch address.
- core_ack  out  1  one-cycle completion pulse to core.
- rsp_rdata  out  INST_WIDTH  read data; valid only while an ack is high.
- rsp_err  out  1  timeout flag; valid only while an ack is high.
- busy  out  1  high in every state except IDLE.
- mem_we  out  1  memory write enable.
- mem_request  out  1  one-cycle request pulse to memory.
- mem_addr  out  INST_ADDR_WIDTH  memory address.
- mem_wdata  out  INST_WIDTH  memory write data.
- mem_valid  in  1  memory completion strobe (reads and writes).
- mem_rdata  in  INST_WIDTH  memory read data, qualified by mem_valid.

Behaviour:
- All outputs are registered. Reset values:
  - state=IDLE, last_grant=LD (so the core wins the first tie).
  - All acks, mem_request, mem_we, busy and rsp_err are 0.
  - mem_addr, mem_wdata and rsp_rdata are 0.
  - Timeout counter is 0.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: requests are sampled only here.
  - Only one requester active: grant it.
  - Both active: grant the one not equal to last_grant.
  - On grant, latch owner, we (core: 0), addr and wdata into the mem_* registers; update last_grant; go to ISSUE.
  - Neither active: stay in IDLE.
- ISSUE: mem_request=1 for exactly this one cycle.
  - mem_valid=1 in this cycle: capture mem_rdata, go to RESP (zero-wait memory).
  - Otherwise: clear the counter, go to WAIT.
- WAIT: mem_request=0.
  - mem_valid=1: capture rdata, go to RESP with err=0.
  - Else, counter==TIMEOUT_CYCLES-1: go to RESP with err=1 and rdata=0.
  - Otherwise: increment the counter.
- RESP: the owner's ack=1 for one cycle, with rsp_rdata and rsp_err driven; the other ack stays 0. Go to IDLE.
- mem_addr, mem_we and mem_wdata hold stable from ISSUE through RESP. mem_we returns to 0 in IDLE.
- Requester rule: drop req on the clock edge that ends its ack cycle. Req may be re-raised immediately, and it is re-sampled in the IDLE cycle after RESP.
- Request changes during ISSUE, WAIT or RESP are ignored; the latched command is used.
- Latency:
  - Zero-wait memory: req seen at cycle N, mem_request at N+1, ack at N+2, next grant decision at N+3.
  - A memory valid k cycles after the request: ack at N+2+k.
  - Timeout: ack at N+2+TIMEOUT_CYCLES with rsp_err=1.
- A mem_valid arriving in IDLE or RESP (late or stray) is ignored, with no state change.
- rst asserted in any state: the next state is IDLE with reset values. An in-flight transaction is abandoned and no ack is issued.
- The core is never granted a write; mem_we is 1 only for loader writes.

Decomposition:
- Package inst_mem_pkg holds:
  - State encoding enum (IDLE, ISSUE, WAIT, RESP, 2 bits).
  - Owner encoding (OWN_LD, OWN_CORE).
  - Shared INST_WIDTH/INST_ADDR_WIDTH defaults.
- One natural sub-module: rr_arb2, a 2-way round-robin picker holding last_grant, with an update-on-grant input. Everything else is flat.

Test Plan:
- Core read, zero-wait memory (mem_valid in ISSUE, rdata=32'hDEAD_BEEF): core_req at cycle 0, addr=7'h05 -> mem_request=1 at cycle 1 with mem_addr=5, mem_we=0; core_ack=1 at cycle 2 with rsp_rdata=DEADBEEF, rsp_err=0.
- Loader write, 3-cycle memory: ld_we=1, addr=7'h10, wdata=32'h0000_0013 -> mem_we=1 and addr/wdata stable from ISSUE until ld_ack, ld_ack 5 cycles after req, core_ack stays 0.
- Simultaneous requests held continuously -> grant order CORE, LD, CORE, LD (first tie goes to the core after reset); each ack goes only to its owner.
- Memory never responds, TIMEOUT_CYCLES=15 -> ack at cycle 17 with rsp_err=1 and rsp_rdata=0. A later stray mem_valid in IDLE causes no ack and no state change.
- rst pulsed during WAIT of a loader write -> next cycle: IDLE, busy=0, mem_request=0, mem_we=0, no ld_ack. A subsequent core read completes normally.
- Back-to-back core fetches: req re-raised at the ack edge -> a new mem_request exactly 2 cycles after the previous ack, with addresses incrementing 0..31 in order.
